// File: rtl/ct_f_spsram_taint_gen_if.sv
// Access bus for the taint-tracking single-port SRAM: request fields with
// their taint companions, plus read data, read taint, valid strobe and ready.
interface ct_f_spsram_taint_gen_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 128,
  parameter int WEN_GRAN   = 1
);
  localparam int LANES = DATA_WIDTH / WEN_GRAN;

  logic [ADDR_WIDTH-1:0] A;
  logic [ADDR_WIDTH-1:0] A_t0;
  logic                  CEN;
  logic                  CEN_t0;
  logic                  GWEN;
  logic                  GWEN_t0;
  logic [LANES-1:0]      WEN;
  logic [LANES-1:0]      WEN_t0;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] D_t0;
  logic [DATA_WIDTH-1:0] Q;
  logic [DATA_WIDTH-1:0] Q_t0;
  logic                  Q_VLD;
  logic                  READY;

  modport master (
    output A, A_t0, CEN, CEN_t0, GWEN, GWEN_t0, WEN, WEN_t0, D, D_t0,
    input  Q, Q_t0, Q_VLD, READY
  );

  modport slave (
    input  A, A_t0, CEN, CEN_t0, GWEN, GWEN_t0, WEN, WEN_t0, D, D_t0,
    output Q, Q_t0, Q_VLD, READY
  );
endinterface

// File: rtl/ct_f_spsram_taint_gen.sv
// Single-port SRAM leaf with a per-bit taint shadow. The shadow is cleared by
// a one-entry-per-cycle sweep after reset; the data array itself is never
// reset. Read latency is 1 (array output register) or 2 (extra output
// register). WEN_GRAN must divide DATA_WIDTH; RD_LAT other than 2 acts as 1.
module ct_f_spsram_taint_gen #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 128,
  parameter int WEN_GRAN   = 1,
  parameter int RD_LAT     = 1,
  parameter int RDW_MODE   = 0
) (
  input logic                    CLK,
  input logic                    RST,
  ct_f_spsram_taint_gen_if.slave bus
);
  localparam int   LANES  = DATA_WIDTH / WEN_GRAN;
  localparam int   DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic RDW_EN = (RDW_MODE != 0);

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  // Replicate each lane-level flag across the bits of its lane.
  function automatic logic [DATA_WIDTH-1:0] lane_expand(input logic [LANES-1:0] m);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) r[l*WEN_GRAN +: WEN_GRAN] = {WEN_GRAN{m[l]}};
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] mem    [DEPTH];
  logic [DATA_WIDTH-1:0] shadow [DEPTH];

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  ready, clr;
  logic [ADDR_WIDTH-1:0] a_hold;

  logic                  live, acc, rd, wr, ctl_t, phantom;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [LANES-1:0]      lane_wr, sh_upd;
  logic [DATA_WIDTH-1:0] wr_bits, upd_bits, sh_new;
  logic [DATA_WIDTH-1:0] rd_word, sh_word, merge_q, merge_qt;

  logic [DATA_WIDTH-1:0] q_p0, qt_p0;
  logic                  vld_p0;

  // FSM state register: reset always restarts the shadow sweep.
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_INIT;
    else     state <= state_nxt;
  end

  // FSM next state: leave INIT once the last shadow entry has been cleared.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (ptr == '1) state_nxt = ST_IDLE;
      ST_IDLE: state_nxt = ST_IDLE;
      default: state_nxt = ST_INIT;
    endcase
  end

  // FSM outputs: sweep enable while initialising, ready once idle.
  always_comb begin
    ready = 1'b0;
    clr   = 1'b0;
    case (state)
      ST_INIT: clr   = 1'b1;
      ST_IDLE: ready = 1'b1;
      default: clr   = 1'b1;
    endcase
  end

  // Sweep pointer walks every shadow entry once per INIT.
  always_ff @(posedge CLK) begin
    if (RST)      ptr <= '0;
    else if (clr) ptr <= ptr + 1'b1;
  end

  // Access decode and conservative taint propagation. A tainted control
  // field means a write may have hit any lane of shadow[A].
  always_comb begin
    live     = ready & ~RST;
    acc      = live & ~bus.CEN;
    rd       = acc & bus.GWEN;
    wr       = acc & ~bus.GWEN;
    ctl_t    = live & ((|bus.A_t0) | bus.CEN_t0 | bus.GWEN_t0);
    phantom  = live & bus.CEN & bus.CEN_t0;
    rd_addr  = acc ? bus.A : a_hold;
    lane_wr  = {LANES{wr}} & ~bus.WEN;
    sh_upd   = {LANES{live}} & (lane_wr | {LANES{ctl_t}} | bus.WEN_t0);
    wr_bits  = lane_expand(lane_wr);
    upd_bits = lane_expand(sh_upd);
    sh_new   = bus.D_t0 | {DATA_WIDTH{ctl_t}} | lane_expand(bus.WEN_t0);
    rd_word  = mem[rd_addr];
    sh_word  = shadow[bus.A];
    merge_q  = (bus.D & wr_bits) | (rd_word & ~wr_bits);
    merge_qt = (sh_new & upd_bits) | (sh_word & ~upd_bits) | {DATA_WIDTH{ctl_t}};
  end

  // Address latch keeps the last accepted address, as a real SRAM would.
  always_ff @(posedge CLK) begin
    if (RST)      a_hold <= '0;
    else if (acc) a_hold <= bus.A;
  end

  // Data array: lane-masked write, no reset.
  always_ff @(posedge CLK) begin
    for (int l = 0; l < LANES; l++)
      if (lane_wr[l]) mem[bus.A][l*WEN_GRAN +: WEN_GRAN] <= bus.D[l*WEN_GRAN +: WEN_GRAN];
  end

  // Taint shadow: swept to zero in INIT, otherwise lane-masked update.
  always_ff @(posedge CLK) begin
    if (clr) begin
      shadow[ptr] <= '0;
    end else begin
      for (int l = 0; l < LANES; l++)
        if (sh_upd[l]) shadow[bus.A][l*WEN_GRAN +: WEN_GRAN] <= sh_new[l*WEN_GRAN +: WEN_GRAN];
    end
  end

  // ---- stage p0: array output register ----
  // Loads on reads and (write-through) writes; a tainted idle CEN forces
  // all-ones taint without a valid strobe. Otherwise Q/Q_t0 hold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_p0   <= '0;
      qt_p0  <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= rd | (wr & RDW_EN);
      if (rd) begin
        q_p0  <= rd_word;
        qt_p0 <= sh_word | {DATA_WIDTH{ctl_t}};
      end else if (wr && RDW_EN) begin
        q_p0  <= merge_q;
        qt_p0 <= merge_qt;
      end else if (phantom) begin
        q_p0  <= rd_word;
        qt_p0 <= '1;
      end
    end
  end

  assign bus.READY = ready;

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] q_p1, qt_p1;
    logic                  vld_p1;

    // ---- stage p1: output register, copies p0 every cycle ----
    always_ff @(posedge CLK) begin
      if (RST) begin
        q_p1   <= '0;
        qt_p1  <= '0;
        vld_p1 <= 1'b0;
      end else begin
        q_p1   <= q_p0;
        qt_p1  <= qt_p0;
        vld_p1 <= vld_p0;
      end
    end

    assign bus.Q     = q_p1;
    assign bus.Q_t0  = qt_p1;
    assign bus.Q_VLD = vld_p1;
  end else begin : g_lat1
    assign bus.Q     = q_p0;
    assign bus.Q_t0  = qt_p0;
    assign bus.Q_VLD = vld_p0;
  end
endmodule

// File: tb/tb_ct_f_spsram_taint_gen.sv
// Bench: two instances driven in lockstep with identical accesses.
//  dut_a: RD_LAT=1, RDW_MODE=0, WEN_GRAN=1 (lane mask expanded per bit)
//  dut_b: RD_LAT=2, RDW_MODE=1, WEN_GRAN=8
module tb_ct_f_spsram_taint_gen;
  localparam int AW = 4;
  localparam int DW = 128;
  localparam int NL = 16;
  localparam int NV = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ct_f_spsram_taint_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WEN_GRAN(1)) bus_a ();
  ct_f_spsram_taint_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WEN_GRAN(8)) bus_b ();

  ct_f_spsram_taint_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WEN_GRAN(1),
                          .RD_LAT(1), .RDW_MODE(0)) dut_a (.CLK(clk), .RST(rst), .bus(bus_a));
  ct_f_spsram_taint_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WEN_GRAN(8),
                          .RD_LAT(2), .RDW_MODE(1)) dut_b (.CLK(clk), .RST(rst), .bus(bus_b));

  typedef struct {
    logic          cen;
    logic          gwen;
    logic [AW-1:0] a;
    logic [AW-1:0] a_t0;
    logic          cen_t0;
    logic          gwen_t0;
    logic [NL-1:0] wen;
    logic [NL-1:0] wen_t0;
    logic [DW-1:0] d;
    logic [DW-1:0] d_t0;
    logic [DW-1:0] eq;   // expected Q (dut_b for writes, both for reads)
    logic [DW-1:0] eqt;  // expected Q_t0
    logic          cq;   // Q is checkable
  } vec_t;

  vec_t vecs [NV];
  int checks = 0;
  int errors = 0;

  localparam logic [DW-1:0] ONES = '1;
  localparam logic [DW-1:0] P    = {16{8'hA5}};
  localparam logic [DW-1:0] P2   = {8{16'h5A3C}};
  localparam logic [DW-1:0] D7   = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
  localparam logic [DW-1:0] Q2   = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [DW-1:0] D13  = {4{32'hDEADBEEF}};
  localparam logic [DW-1:0] B5   = 128'h20;
  localparam logic [DW-1:0] BY0  = 128'hFF;
  localparam logic [DW-1:0] BY1  = 128'hFF00;

  function automatic vec_t mk(input logic cen, input logic gwen, input logic [AW-1:0] a,
                              input logic [AW-1:0] a_t0, input logic cen_t0,
                              input logic [NL-1:0] wen, input logic [NL-1:0] wen_t0,
                              input logic [DW-1:0] d, input logic [DW-1:0] d_t0,
                              input logic [DW-1:0] eq, input logic [DW-1:0] eqt, input logic cq);
    vec_t v;
    v.cen = cen; v.gwen = gwen; v.a = a; v.a_t0 = a_t0; v.cen_t0 = cen_t0; v.gwen_t0 = 1'b0;
    v.wen = wen; v.wen_t0 = wen_t0; v.d = d; v.d_t0 = d_t0; v.eq = eq; v.eqt = eqt; v.cq = cq;
    return v;
  endfunction

  function automatic logic [DW-1:0] expand8(input logic [NL-1:0] m);
    logic [DW-1:0] r;
    r = '0;
    for (int l = 0; l < NL; l++) r[l*8 +: 8] = {8{m[l]}};
    return r;
  endfunction

  task automatic drive(input vec_t v);
    bus_a.CEN = v.cen;   bus_a.CEN_t0 = v.cen_t0; bus_a.GWEN = v.gwen; bus_a.GWEN_t0 = v.gwen_t0;
    bus_a.A = v.a;       bus_a.A_t0 = v.a_t0;     bus_a.D = v.d;       bus_a.D_t0 = v.d_t0;
    bus_a.WEN = expand8(v.wen); bus_a.WEN_t0 = expand8(v.wen_t0);
    bus_b.CEN = v.cen;   bus_b.CEN_t0 = v.cen_t0; bus_b.GWEN = v.gwen; bus_b.GWEN_t0 = v.gwen_t0;
    bus_b.A = v.a;       bus_b.A_t0 = v.a_t0;     bus_b.D = v.d;       bus_b.D_t0 = v.d_t0;
    bus_b.WEN = v.wen;   bus_b.WEN_t0 = v.wen_t0;
  endtask

  task automatic drive_idle();
    drive(mk(1'b1, 1'b1, '0, '0, 1'b0, '1, '0, '0, '0, '0, '0, 1'b0));
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Count posedges after RST drops until READY is seen; both must read 16.
  task automatic wait_ready(input string name);
    int fa, fb;
    fa = 0;
    fb = 0;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk);
      #1;
      if (fa == 0 && bus_a.READY) fa = i;
      if (fb == 0 && bus_b.READY) fb = i;
    end
    chk({name, "_a"}, DW'(fa), DW'(16));
    chk({name, "_b"}, DW'(fb), DW'(16));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [DW-1:0] pa_q, pa_qt;
    logic          pa_known, is_rd, is_wr, is_ph;
    vec_t          v;

    //            cen  gwen a   a_t0 ct0  wen      wen_t0   d     d_t0  eq    eqt   cq
    vecs[0]  = mk(1'b0, 1'b0, 3,  0, 1'b0, 16'h0000, 16'h0000, P,    '0,   P,    '0,   1'b1);
    vecs[1]  = mk(1'b0, 1'b1, 3,  0, 1'b0, 16'hFFFF, 16'h0000, '0,   '0,   P,    '0,   1'b1);
    vecs[2]  = mk(1'b0, 1'b0, 5,  0, 1'b0, 16'h0000, 16'h0000, '0,   '0,   '0,   '0,   1'b1);
    vecs[3]  = mk(1'b0, 1'b0, 5,  0, 1'b0, 16'hFFFE, 16'h0000, ONES, '0,   BY0,  '0,   1'b1);
    vecs[4]  = mk(1'b0, 1'b1, 5,  0, 1'b0, 16'hFFFF, 16'h0000, '0,   '0,   BY0,  '0,   1'b1);
    vecs[5]  = mk(1'b0, 1'b0, 7,  0, 1'b0, 16'h0000, 16'h0000, D7,   B5,   D7,   B5,   1'b1);
    vecs[6]  = mk(1'b0, 1'b1, 7,  0, 1'b0, 16'hFFFF, 16'h0000, '0,   '0,   D7,   B5,   1'b1);
    vecs[7]  = mk(1'b0, 1'b1, 3,  1, 1'b0, 16'hFFFF, 16'h0000, '0,   '0,   P,    ONES, 1'b1);
    vecs[8]  = mk(1'b1, 1'b1, 0,  0, 1'b1, 16'hFFFF, 16'h0000, '0,   '0,   '0,   ONES, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 7,  0, 1'b0, 16'h0000, 16'h0000, Q2,   '0,   Q2,   '0,   1'b1);
    vecs[10] = mk(1'b0, 1'b1, 7,  0, 1'b0, 16'hFFFF, 16'h0000, '0,   '0,   Q2,   '0,   1'b1);
    vecs[11] = mk(1'b0, 1'b0, 9,  0, 1'b0, 16'h0000, 16'h0000, '0,   '0,   '0,   '0,   1'b1);
    vecs[12] = mk(1'b0, 1'b0, 9,  0, 1'b0, 16'hFFFF, 16'h0002, ONES, '0,   '0,   BY1,  1'b1);
    vecs[13] = mk(1'b0, 1'b1, 9,  0, 1'b0, 16'hFFFF, 16'h0000, '0,   '0,   '0,   BY1,  1'b1);
    vecs[14] = mk(1'b0, 1'b0, 13, 0, 1'b0, 16'h0000, 16'h0000, D13,  ONES, D13,  ONES, 1'b1);
    vecs[15] = mk(1'b0, 1'b1, 13, 0, 1'b0, 16'hFFFF, 16'h0000, '0,   '0,   D13,  ONES, 1'b1);

    // Reset state and first INIT sweep
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    chk("rst_q_a",   bus_a.Q, '0);
    chk("rst_qt_a",  bus_a.Q_t0, '0);
    chk("rst_vld_a", DW'(bus_a.Q_VLD), '0);
    chk("rst_rdy_a", DW'(bus_a.READY), '0);
    chk("rst_q_b",   bus_b.Q, '0);
    chk("rst_qt_b",  bus_b.Q_t0, '0);
    chk("rst_rdy_b", DW'(bus_b.READY), '0);
    rst = 1'b0;
    wait_ready("init1");

    // Table: one access, then idle until dut_b has produced its result
    pa_q = '0;
    pa_qt = '0;
    pa_known = 1'b1;
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      drive(v);
      @(negedge clk);
      drive_idle();
      is_rd = !v.cen && v.gwen;
      is_wr = !v.cen && !v.gwen;
      is_ph = v.cen && v.cen_t0;
      if (is_rd) begin
        pa_q = v.eq;
        pa_qt = v.eqt;
        pa_known = 1'b1;
      end else if (is_ph) begin
        pa_qt = ONES;
        pa_known = 1'b0;
      end
      chk($sformatf("v%0d_vld_a", i), DW'(bus_a.Q_VLD), DW'(is_rd));
      chk($sformatf("v%0d_qt_a", i), bus_a.Q_t0, pa_qt);
      if (pa_known) chk($sformatf("v%0d_q_a", i), bus_a.Q, pa_q);
      @(negedge clk);
      chk($sformatf("v%0d_hold_vld_a", i), DW'(bus_a.Q_VLD), '0);
      chk($sformatf("v%0d_hold_qt_a", i), bus_a.Q_t0, pa_qt);
      if (pa_known) chk($sformatf("v%0d_hold_q_a", i), bus_a.Q, pa_q);
      chk($sformatf("v%0d_vld_b", i), DW'(bus_b.Q_VLD), DW'(is_rd || is_wr));
      chk($sformatf("v%0d_qt_b", i), bus_b.Q_t0, v.eqt);
      if (v.cq) chk($sformatf("v%0d_q_b", i), bus_b.Q, v.eq);
    end

    // Back-to-back reads: one result per cycle on both latencies
    drive(mk(1'b0, 1'b1, 5, 0, 1'b0, '1, '0, '0, '0, '0, '0, 1'b0));
    @(negedge clk);
    drive(mk(1'b0, 1'b1, 7, 0, 1'b0, '1, '0, '0, '0, '0, '0, 1'b0));
    chk("b2b_q0_a", bus_a.Q, BY0);
    chk("b2b_vld0_a", DW'(bus_a.Q_VLD), 1);
    @(negedge clk);
    drive_idle();
    chk("b2b_q1_a", bus_a.Q, Q2);
    chk("b2b_vld1_a", DW'(bus_a.Q_VLD), 1);
    chk("b2b_q0_b", bus_b.Q, BY0);
    chk("b2b_vld0_b", DW'(bus_b.Q_VLD), 1);
    @(negedge clk);
    chk("b2b_q1_b", bus_b.Q, Q2);
    chk("b2b_vld1_b", DW'(bus_b.Q_VLD), 1);

    // Write immediately followed by read of the same address
    drive(mk(1'b0, 1'b0, 11, 0, 1'b0, '0, '0, P2, '0, '0, '0, 1'b0));
    @(negedge clk);
    drive(mk(1'b0, 1'b1, 11, 0, 1'b0, '1, '0, '0, '0, '0, '0, 1'b0));
    @(negedge clk);
    drive_idle();
    chk("raw_q_a", bus_a.Q, P2);
    chk("raw_qt_a", bus_a.Q_t0, '0);
    chk("raw_wt_q_b", bus_b.Q, P2);
    chk("raw_wt_vld_b", DW'(bus_b.Q_VLD), 1);
    @(negedge clk);
    chk("raw_q_b", bus_b.Q, P2);
    chk("raw_qt_b", bus_b.Q_t0, '0);
    chk("raw_vld_b", DW'(bus_b.Q_VLD), 1);

    // Reset lands while dut_b's read of tainted address 13 is in flight
    drive(mk(1'b0, 1'b1, 13, 0, 1'b0, '1, '0, '0, '0, '0, '0, 1'b0));
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    chk("abort_pre_q_a", bus_a.Q, D13);
    chk("abort_pre_qt_a", bus_a.Q_t0, ONES);
    @(negedge clk);
    chk("abort_vld_b", DW'(bus_b.Q_VLD), '0);
    chk("abort_q_b", bus_b.Q, '0);
    chk("abort_qt_b", bus_b.Q_t0, '0);
    chk("abort_rdy_b", DW'(bus_b.READY), '0);
    chk("abort_q_a", bus_a.Q, '0);
    rst = 1'b0;
    wait_ready("init2");
    drive(mk(1'b0, 1'b1, 13, 0, 1'b0, '1, '0, '0, '0, '0, '0, 1'b0));
    @(negedge clk);
    drive_idle();
    chk("post_q_a", bus_a.Q, D13);
    chk("post_qt_a", bus_a.Q_t0, '0);
    chk("post_vld_a", DW'(bus_a.Q_VLD), 1);
    @(negedge clk);
    chk("post_q_b", bus_b.Q, D13);
    chk("post_qt_b", bus_b.Q_t0, '0);
    chk("post_vld_b", DW'(bus_b.Q_VLD), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
